imm_ext_pipe: RTL and testbench

- Registered, parametrised immediate extender for the ID→EX boundary of the pipelined MIPS core.
- Widens an IN_W-bit instruction immediate to OUT_W bits in one of four modes: sign, zero, LUI, or branch-offset shift.
- Buffers results in a 2-entry skid buffer with valid/ready handshake and flush, so EX back-pressure never drops an immediate.
- Carries a sideband tag (e.g. destination register) alongside each result.

---
 rtl/imm_ext_pipe.sv | 176 +++++++++++++++++
 tb/tb_imm_ext_pipe.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/imm_ext_pipe.sv
// imm_ext_pipe: registered immediate extender for the ID->EX boundary.
// Widens an IN_W-bit immediate to OUT_W bits (sign / zero / LUI / branch)
// and holds results in a 2-entry skid buffer with a sideband tag.
// Optional stall statistics counter is built when IMM_EXT_STATS_EN is defined.
//
// Handshake: an input transfer happens on a rising edge where
// in_valid && in_ready; an output transfer happens on a rising edge where
// out_valid && out_ready. in_ready depends only on registered state, and
// data_out/out_tag stay stable while out_valid && !out_ready.
module imm_ext_pipe #(
  parameter int IN_W     = 16,
  parameter int OUT_W    = 32,
  parameter int BR_SHIFT = 2,
  parameter int TAG_W    = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  instr_part,
  input  logic [1:0]       mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] data_out,
  output logic [TAG_W-1:0] out_tag,
  output logic [15:0]      stall_cnt,
  output logic [1:0]       dbg_state
);

  // The branch shift must not lose immediate bits inside the output word.
  if (OUT_W < IN_W + BR_SHIFT) begin : g_bad_width
    $error("imm_ext_pipe: OUT_W must be >= IN_W + BR_SHIFT");
  end

  localparam logic [1:0] EMPTY = 2'b00;
  localparam logic [1:0] ONE   = 2'b01;
  localparam logic [1:0] FULL  = 2'b10;

  localparam logic [1:0] MODE_SIGN = 2'b00;
  localparam logic [1:0] MODE_ZERO = 2'b01;
  localparam logic [1:0] MODE_LUI  = 2'b10;

  logic [1:0]       state_q, state_d;
  logic [OUT_W-1:0] head_data_q, head_data_d;
  logic [TAG_W-1:0] head_tag_q, head_tag_d;
  logic [OUT_W-1:0] skid_data_q, skid_data_d;
  logic [TAG_W-1:0] skid_tag_q, skid_tag_d;

  logic signed [IN_W-1:0] imm_s;
  logic [OUT_W-1:0] sext;
  logic [OUT_W-1:0] ext;
  logic             in_fire, out_fire;
  logic             head_load, head_from_skid, skid_load;

  assign imm_s     = instr_part;
  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign data_out  = head_data_q;
  assign out_tag   = head_tag_q;
  assign dbg_state = state_q;

  // Combinational extension of the incoming immediate according to mode.
  always_comb begin
    sext = OUT_W'(imm_s);
    ext  = sext;
    case (mode)
      MODE_SIGN: ext = sext;
      MODE_ZERO: ext = OUT_W'(instr_part);
      MODE_LUI:  ext = OUT_W'(instr_part) << (OUT_W - IN_W);
      default:   ext = sext << BR_SHIFT;
    endcase
  end

  // Next-state and load-enable decode; flush overrides every transition.
  always_comb begin
    state_d        = state_q;
    head_load      = 1'b0;
    head_from_skid = 1'b0;
    skid_load      = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d   = ONE;
            head_load = 1'b1;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            head_load = 1'b1;
          end else if (in_fire) begin
            state_d   = FULL;
            skid_load = 1'b1;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            state_d        = ONE;
            head_from_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Data path muxing for the head and skid entries.
  always_comb begin
    head_data_d = head_data_q;
    head_tag_d  = head_tag_q;
    skid_data_d = skid_data_q;
    skid_tag_d  = skid_tag_q;
    if (head_load) begin
      head_data_d = ext;
      head_tag_d  = in_tag;
    end else if (head_from_skid) begin
      head_data_d = skid_data_q;
      head_tag_d  = skid_tag_q;
    end
    if (skid_load) begin
      skid_data_d = ext;
      skid_tag_d  = in_tag;
    end
  end

  // State and entry registers; reset drops all entries at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      head_data_q <= '0;
      head_tag_q  <= '0;
      skid_data_q <= '0;
      skid_tag_q  <= '0;
    end else begin
      state_q     <= state_d;
      head_data_q <= head_data_d;
      head_tag_q  <= head_tag_d;
      skid_data_q <= skid_data_d;
      skid_tag_q  <= skid_tag_d;
    end
  end

`ifdef IMM_EXT_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of cycles where the head is held by the consumer.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid && !out_ready && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  // Counter register, cleared only by reset (flush leaves it alone).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 16'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_imm_ext_pipe.sv
// tb_imm_ext_pipe: directed bench for imm_ext_pipe with hand-computed
// expected values. Honours IMM_EXT_STATS_EN for the stall counter checks.
module tb_imm_ext_pipe;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] instr_part;
  logic [1:0]  mode;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] data_out;
  logic [4:0]  out_tag;
  logic [15:0] stall_cnt;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_q[$];
  logic [15:0] vec_imm[12];
  logic [31:0] vec_exp[12];
  logic [31:0] held_data;

  imm_ext_pipe dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .instr_part (instr_part),
    .mode       (mode),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .data_out   (data_out),
    .out_tag    (out_tag),
    .stall_cnt  (stall_cnt),
    .dbg_state  (dbg_state)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Checking task: every comparison goes through here.
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp_v);
    end
  endtask

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_in(input logic v, input logic [15:0] imm, input logic [1:0] m,
                          input logic [4:0] tg);
    in_valid   = v;
    instr_part = imm;
    mode       = m;
    in_tag     = tg;
  endtask

  initial begin
    // mode sweep table: 0x8004, 0x7FFF, 0xFFFF across sign/zero/lui/branch
    vec_imm[0]  = 16'h8004; vec_exp[0]  = 32'hFFFF8004;
    vec_imm[1]  = 16'h8004; vec_exp[1]  = 32'h00008004;
    vec_imm[2]  = 16'h8004; vec_exp[2]  = 32'h80040000;
    vec_imm[3]  = 16'h8004; vec_exp[3]  = 32'hFFFE0010;
    vec_imm[4]  = 16'h7FFF; vec_exp[4]  = 32'h00007FFF;
    vec_imm[5]  = 16'h7FFF; vec_exp[5]  = 32'h00007FFF;
    vec_imm[6]  = 16'h7FFF; vec_exp[6]  = 32'h7FFF0000;
    vec_imm[7]  = 16'h7FFF; vec_exp[7]  = 32'h0001FFFC;
    vec_imm[8]  = 16'hFFFF; vec_exp[8]  = 32'hFFFFFFFF;
    vec_imm[9]  = 16'hFFFF; vec_exp[9]  = 32'h0000FFFF;
    vec_imm[10] = 16'hFFFF; vec_exp[10] = 32'hFFFF0000;
    vec_imm[11] = 16'hFFFF; vec_exp[11] = 32'hFFFFFFFC;

    rst_n     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    drive_in(1'b0, 16'h0, 2'b00, 5'd0);
    step();
    step();
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_in_ready",  32'(in_ready),  32'd1);
    check_eq("rst_data_out",  data_out,       32'd0);
    check_eq("rst_out_tag",   32'(out_tag),   32'd0);
    check_eq("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    rst_n = 1'b1;
    step();

    // Mode sweep with out_ready=1: each result appears the next cycle
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      drive_in(1'b1, vec_imm[i], 2'(i), 5'(i));
      step();
      check_eq("sweep_valid", 32'(out_valid), 32'd1);
      check_eq("sweep_data",  data_out,       vec_exp[i]);
      check_eq("sweep_tag",   32'(out_tag),   32'(i));
    end
    drive_in(1'b0, 16'h0, 2'b00, 5'd0);
    step();
    check_eq("sweep_drain_valid", 32'(out_valid), 32'd0);

    // Back-pressure: tags 1,2,3 with out_ready=0
    out_ready = 1'b0;
    drive_in(1'b1, 16'd1, 2'b01, 5'd1);
    exp_q.push_back(32'd1);
    step();
    check_eq("bp_ready_after1", 32'(in_ready), 32'd1);
    drive_in(1'b1, 16'd2, 2'b01, 5'd2);
    exp_q.push_back(32'd2);
    step();
    check_eq("bp_ready_after2", 32'(in_ready), 32'd0);
    drive_in(1'b1, 16'd3, 2'b01, 5'd3);
    exp_q.push_back(32'd3);
    step();
    check_eq("bp_ready_held",  32'(in_ready), 32'd0);
    check_eq("bp_head_stable", data_out,      32'd1);
    check_eq("bp_tag_stable",  32'(out_tag),  exp_q[0]);
    out_ready = 1'b1;
    // head 1 leaves at this edge; tag 3 is still held upstream until in_ready
    for (int k = 0; k < 3; k++) begin
      check_eq("bp_order_valid", 32'(out_valid), 32'd1);
      check_eq("bp_order_tag",   32'(out_tag),   exp_q[0]);
      check_eq("bp_order_data",  data_out,       exp_q[0]);
      void'(exp_q.pop_front());
      step();
      if (k == 1) drive_in(1'b0, 16'h0, 2'b00, 5'd0);
    end
    check_eq("bp_drained_valid", 32'(out_valid), 32'd0);
    check_eq("bp_queue_empty",   32'(exp_q.size()), 32'd0);

    // Throughput: simultaneous in/out for 10 cycles after the first load
    out_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      drive_in(1'b1, 16'(i + 100), 2'b01, 5'(i + 5));
      step();
      check_eq("tp_tag",   32'(out_tag),  32'(i + 5));
      check_eq("tp_data",  data_out,      32'(i + 100));
      check_eq("tp_ready", 32'(in_ready), 32'd1);
    end
    drive_in(1'b0, 16'h0, 2'b00, 5'd0);
    step();

    // Flush while FULL with a concurrent input
    out_ready = 1'b0;
    drive_in(1'b1, 16'h0A0A, 2'b01, 5'd10);
    step();
    drive_in(1'b1, 16'h0B0B, 2'b01, 5'd11);
    step();
    check_eq("fl_full_ready", 32'(in_ready), 32'd0);
    held_data = 32'h00000A0A;
    flush = 1'b1;
    drive_in(1'b1, 16'h0C0C, 2'b01, 5'd12);
    step();
    flush = 1'b0;
    drive_in(1'b0, 16'h0, 2'b00, 5'd0);
    check_eq("fl_valid",     32'(out_valid), 32'd0);
    check_eq("fl_ready",     32'(in_ready),  32'd1);
    check_eq("fl_data_hold", data_out,       held_data);
    check_eq("fl_tag_hold",  32'(out_tag),   32'd10);
    step();
    check_eq("fl_stay_empty", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    drive_in(1'b1, 16'h0D0D, 2'b01, 5'd13);
    step();
    drive_in(1'b0, 16'h0, 2'b00, 5'd0);
    check_eq("fl_next_tag",  32'(out_tag), 32'd13);
    check_eq("fl_next_data", data_out,     32'h00000D0D);
    step();
    check_eq("fl_next_gone", 32'(out_valid), 32'd0);

    // Asynchronous reset mid-transfer, no clock edge in between
    out_ready = 1'b0;
    drive_in(1'b1, 16'h1414, 2'b01, 5'd20);
    step();
    drive_in(1'b1, 16'h1515, 2'b01, 5'd21);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("ar_valid", 32'(out_valid), 32'd0);
    check_eq("ar_ready", 32'(in_ready),  32'd1);
    check_eq("ar_data",  data_out,       32'd0);
    check_eq("ar_tag",   32'(out_tag),   32'd0);
    check_eq("ar_stall", 32'(stall_cnt), 32'd0);
    drive_in(1'b0, 16'h0, 2'b00, 5'd0);
    #3;
    rst_n = 1'b1;
    step();

    // Stall counter: hold head for 5 cycles
    out_ready = 1'b0;
    drive_in(1'b1, 16'h0042, 2'b00, 5'd7);
    step();
    drive_in(1'b0, 16'h0, 2'b00, 5'd0);
    for (int i = 0; i < 5; i++) step();
    check_eq("st_head_tag", 32'(out_tag), 32'd7);
`ifdef IMM_EXT_STATS_EN
    check_eq("st_cnt5", 32'(stall_cnt), 32'd5);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check_eq("st_flush_keeps", 32'(stall_cnt), 32'd6);
    drive_in(1'b1, 16'h0043, 2'b00, 5'd8);
    step();
    drive_in(1'b0, 16'h0, 2'b00, 5'd0);
    for (int i = 0; i < 70000; i++) @(posedge clk);
    #1;
    check_eq("st_saturate", 32'(stall_cnt), 32'h0000FFFF);
`else
    check_eq("st_tied_zero", 32'(stall_cnt), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
